consumer_stall_ctrl: RTL and testbench
======================================

// Module: consumer_stall_ctrl
// PURPOSE
//  Consumer end of the dual-lane pipeline. Accepts the two pipeline output lanes
//  (data+valid) into per-lane FIFOs and drains them through one rate-limited,
//  round-robin output port. It is the only source of global_stall: it asserts
//  global_stall early enough that in-flight beats still fit in the FIFOs.
// PARAMETERS
//  DATA_W        32  lane data width
//  DEPTH          4  entries per lane FIFO (power of 2, >=4)
//  STALL_LAT      2  cycles from global_stall assertion until lane valids stop
//  DRAIN_PERIOD   2  cycles between drain opportunities (1 = every cycle)
// PORTS
//  clk             in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-low reset
//  in_data_1       in   DATA_W  lane-1 pipeline output data
//  in_valid_1      in   1       lane-1 beat valid; no ready, push is unconditional
//  in_data_2       in   DATA_W  lane-2 pipeline output data
//  in_valid_2      in   1       lane-2 beat valid
//  drain_en        in   1       1 = drain opportunities allowed
//  global_stall    out  1       registered stall to producer and pipeline
//  out_data        out  DATA_W  drained beat
//  out_lane        out  1       0 = lane 1, 1 = lane 2
//  out_valid       out  1       drained beat valid, one cycle
//  overflow_1/_2   out  1       sticky: lane beat dropped because FIFO full
//  drained_cnt     out  16      total beats drained, wraps at 2^16
// BEHAVIOUR
//  - Reset (reset==0, async): FIFOs empty, pointers 0, all outputs 0,
//    rr_last=lane 2 (lane 1 is served first), drain timer 0.
//  - Push: in_valid_k=1 writes in_data_k to FIFO k in the same cycle.
//    If count_k==DEPTH and no pop of lane k this cycle: beat dropped,
//    overflow_k<=1 (clears only on reset). Push+pop together when full: accepted.
//  - Drain timer counts 0..DRAIN_PERIOD-1 and wraps. A drain opportunity is
//    timer==DRAIN_PERIOD-1 && drain_en. The timer runs even when drain_en=0.
//  - At a drain opportunity, pick a non-empty lane round-robin, starting with
//    the lane after rr_last. If only one lane is non-empty, pick it. If none,
//    do nothing. Pop the head entry. Next cycle: out_valid=1, out_data=head,
//    out_lane=lane, drained_cnt+1. rr_last updates only on an actual pop.
//  - Latency: a beat pushed into an empty FIFO can appear on out_data no
//    earlier than 1 cycle later.
//  - count_k_next = count_k + push_accepted_k - pop_k.
//    global_stall <= (count_1_next >= DEPTH-STALL_LAT) ||
//                    (count_2_next >= DEPTH-STALL_LAT).
//    Deasserts in the cycle after both FIFOs are below the threshold.
//  - Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
//  - Outputs are fully registered; there is no combinational input->output path.
// STRUCTURE
//  - Shared package: LANE_1/LANE_2 constants, DATA_W default,
//    stall threshold function thr(DEPTH,STALL_LAT).
//  - One sub-module, consumer_lane_fifo: sync FIFO with push, pop, head, count.
//    Instantiate it twice.
//  - The arbiter, drain timer, stall logic and counters live in this module.
// TESTING
//  1. Reset mid-operation: fill lane 1 with 3 beats, pulse reset low ->
//     all outputs 0 immediately; after release, no stale beat is drained.
//  2. Round robin: DRAIN_PERIOD=1; preload lane 1 with A1,A2 and lane 2 with
//     B1,B2 -> out order A1,B1,A2,B2 with out_lane 0,1,0,1; drained_cnt=4.
//  3. Stall threshold: DEPTH=4, STALL_LAT=2, drain_en=0; push lane 2 every cycle
//     -> global_stall rises the cycle after the 2nd push; 4 beats held; no overflow.
//  4. Overflow: drain_en=0; push 5 beats on lane 1 -> 5th dropped, overflow_1=1
//     and stays 1; FIFO keeps the first 4 values in order.
//  5. Full push+pop: lane 1 full, drain opportunity coincides with in_valid_1
//     -> beat accepted, count stays 4, overflow_1 stays 0.
//  6. Wrap: stream 20 beats per lane with DRAIN_PERIOD=1 and random drain_en
//     -> every beat is drained once, in order per lane, and no overflow occurs.

Source files
------------

// File: rtl/consumer_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// consumer_stall_ctrl_pkg : shared lane ids, width default, stall threshold
// Rev 1.0
// ============================================================================
package consumer_stall_ctrl_pkg;

  localparam int c_DATA_W = 32;

  typedef enum logic {
    LANE_1 = 1'b0,
    LANE_2 = 1'b1
  } lane_e;

  // Fill level at which the producer must be stopped so in-flight beats still fit.
  function automatic int thr(input int depth, input int stall_lat);
    return depth - stall_lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/consumer_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// consumer_stall_ctrl_if : lane inputs, drain control and drained-beat outputs
// Rev 1.0
// ============================================================================
interface consumer_stall_ctrl_if #(
  parameter int DATA_W = consumer_stall_ctrl_pkg::c_DATA_W
);
  logic [DATA_W-1:0] in_data_1;
  logic              in_valid_1;
  logic [DATA_W-1:0] in_data_2;
  logic              in_valid_2;
  logic              drain_en;
  logic              global_stall;
  logic [DATA_W-1:0] out_data;
  logic              out_lane;
  logic              out_valid;
  logic              overflow_1;
  logic              overflow_2;
  logic [15:0]       drained_cnt;

  modport master (
    output in_data_1, in_valid_1, in_data_2, in_valid_2, drain_en,
    input  global_stall, out_data, out_lane, out_valid,
    input  overflow_1, overflow_2, drained_cnt
  );

  modport slave (
    input  in_data_1, in_valid_1, in_data_2, in_valid_2, drain_en,
    output global_stall, out_data, out_lane, out_valid,
    output overflow_1, overflow_2, drained_cnt
  );
endinterface
`default_nettype wire

// File: rtl/consumer_lane_fifo.sv
`default_nettype none
// ============================================================================
// consumer_lane_fifo : per-lane sync FIFO; caller guarantees no overrun/underrun
// Rev 1.0
// ============================================================================
module consumer_lane_fifo
  import consumer_stall_ctrl_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] head,
  output logic      [AW:0]       count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: emptiness is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wdata;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/consumer_stall_ctrl.sv
`default_nettype none
// ============================================================================
// consumer_stall_ctrl : two lane FIFOs drained round-robin at a limited rate
// Rev 1.0
// ============================================================================
module consumer_stall_ctrl
  import consumer_stall_ctrl_pkg::*;
#(
  parameter int DATA_W       = c_DATA_W,
  parameter int DEPTH        = 4,
  parameter int STALL_LAT    = 2,
  parameter int DRAIN_PERIOD = 2
) (
  input wire logic             clk,
  input wire logic             reset,
  consumer_stall_ctrl_if.slave bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int c_TMR_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(DRAIN_PERIOD - 1);
  localparam logic [AW:0]        c_THR     = (AW+1)'(thr(DEPTH, STALL_LAT));
  localparam logic [AW:0]        c_FULL    = (AW+1)'(DEPTH);

  logic [DATA_W-1:0]  w_head_1, w_head_2;
  logic [AW:0]        w_count_1, w_count_2;
  logic [AW:0]        w_cnext_1, w_cnext_2;
  logic               w_acc_1, w_acc_2;
  logic               w_pop_1, w_pop_2;
  logic               w_any_pop;
  logic               w_opp;
  lane_e              w_sel;

  logic [c_TMR_W-1:0] r_tmr;
  lane_e              r_rr_last;
  logic               r_stall;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  lane_e              r_out_lane;
  logic               r_ovf_1, r_ovf_2;
  logic [15:0]        r_drained_cnt;

  consumer_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk(clk), .reset(reset), .push(w_acc_1), .pop(w_pop_1),
    .wdata(bus.in_data_1), .head(w_head_1), .count(w_count_1)
  );

  consumer_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk(clk), .reset(reset), .push(w_acc_2), .pop(w_pop_2),
    .wdata(bus.in_data_2), .head(w_head_2), .count(w_count_2)
  );

  assign w_opp = (r_tmr == c_TMR_MAX) && bus.drain_en;

  always_comb begin
    w_sel   = LANE_1;
    w_pop_1 = 1'b0;
    w_pop_2 = 1'b0;
    if (w_opp) begin
      if ((w_count_1 != '0) && (w_count_2 != '0))
        w_sel = (r_rr_last == LANE_2) ? LANE_1 : LANE_2;
      else if (w_count_2 != '0)
        w_sel = LANE_2;
      w_pop_1 = (w_count_1 != '0) && (w_sel == LANE_1);
      w_pop_2 = (w_count_2 != '0) && (w_sel == LANE_2);
    end
  end

  assign w_any_pop = w_pop_1 | w_pop_2;

  // A full FIFO still takes a beat when its head leaves in the same cycle.
  assign w_acc_1   = bus.in_valid_1 && ((w_count_1 != c_FULL) || w_pop_1);
  assign w_acc_2   = bus.in_valid_2 && ((w_count_2 != c_FULL) || w_pop_2);
  assign w_cnext_1 = w_count_1 + (AW+1)'(w_acc_1) - (AW+1)'(w_pop_1);
  assign w_cnext_2 = w_count_2 + (AW+1)'(w_acc_2) - (AW+1)'(w_pop_2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmr         <= '0;
      r_rr_last     <= LANE_2;
      r_stall       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_lane    <= LANE_1;
      r_ovf_1       <= 1'b0;
      r_ovf_2       <= 1'b0;
      r_drained_cnt <= '0;
    end else begin
      r_tmr       <= (r_tmr == c_TMR_MAX) ? '0 : r_tmr + c_TMR_W'(1);
      r_stall     <= (w_cnext_1 >= c_THR) || (w_cnext_2 >= c_THR);
      r_ovf_1     <= r_ovf_1 | (bus.in_valid_1 & ~w_acc_1);
      r_ovf_2     <= r_ovf_2 | (bus.in_valid_2 & ~w_acc_2);
      r_out_valid <= w_any_pop;
      if (w_any_pop) begin
        r_out_data    <= (w_sel == LANE_1) ? w_head_1 : w_head_2;
        r_out_lane    <= w_sel;
        r_rr_last     <= w_sel;
        r_drained_cnt <= r_drained_cnt + 16'd1;
      end
    end
  end

  assign bus.global_stall = r_stall;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_lane     = r_out_lane;
  assign bus.overflow_1   = r_ovf_1;
  assign bus.overflow_2   = r_ovf_2;
  assign bus.drained_cnt  = r_drained_cnt;

endmodule
`default_nettype wire

// File: tb/tb_consumer_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_consumer_stall_ctrl : directed bench for consumer_stall_ctrl
// Rev 1.0
// ============================================================================
module tb_consumer_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data_1, in_data_2;
  logic        in_valid_1, in_valid_2, drain_en;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  consumer_stall_ctrl_if #(.DATA_W(32)) bus_a ();
  consumer_stall_ctrl_if #(.DATA_W(32)) bus_b ();

  assign bus_a.in_data_1  = in_data_1;
  assign bus_a.in_valid_1 = in_valid_1;
  assign bus_a.in_data_2  = in_data_2;
  assign bus_a.in_valid_2 = in_valid_2;
  assign bus_a.drain_en   = drain_en;
  assign bus_b.in_data_1  = in_data_1;
  assign bus_b.in_valid_1 = in_valid_1;
  assign bus_b.in_data_2  = in_data_2;
  assign bus_b.in_valid_2 = in_valid_2;
  assign bus_b.drain_en   = drain_en;

  consumer_stall_ctrl #(.DATA_W(32), .DEPTH(4), .STALL_LAT(2), .DRAIN_PERIOD(1)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  consumer_stall_ctrl #(.DATA_W(32), .DEPTH(4), .STALL_LAT(2), .DRAIN_PERIOD(2)) u_dut_p2 (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    in_data_1  = '0;
    in_data_2  = '0;
    drain_en   = 1'b0;
  endtask

  // Asynchronous reset: outputs must be clear before any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_rst_ovalid"}, 32'(bus_a.out_valid), 0);
    check({tag, "_rst_odata"},  bus_a.out_data, 0);
    check({tag, "_rst_olane"},  32'(bus_a.out_lane), 0);
    check({tag, "_rst_stall"},  32'(bus_a.global_stall), 0);
    check({tag, "_rst_ovf"},    32'({bus_a.overflow_1, bus_a.overflow_2}), 0);
    check({tag, "_rst_cnt"},    32'(bus_a.drained_cnt), 0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic        h1, h2, h3;
    int          sent1, sent2, cyc, got;

    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset while lane 1 holds three beats
    in_valid_1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data_1 = 32'h11 + 32'(i);
      tick();
    end
    check("t1_stall_pre", 32'(bus_a.global_stall), 1);
    do_reset("t1");
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_no_stale", 32'(bus_a.out_valid), 0);
    end
    check("t1_cnt", 32'(bus_a.drained_cnt), 0);

    // Round robin: lane 1 first after reset
    do_reset("t2");
    in_valid_1 = 1'b1; in_valid_2 = 1'b1;
    in_data_1 = 32'hA1; in_data_2 = 32'hB1;
    tick();
    in_data_1 = 32'hA2; in_data_2 = 32'hB2;
    tick();
    idle();
    drain_en = 1'b1;
    exp_d = '{32'hA1, 32'hB1, 32'hA2, 32'hB2};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_ovalid", 32'(bus_a.out_valid), 1);
      check("t2_odata", bus_a.out_data, exp_d[i]);
      check("t2_olane", 32'(bus_a.out_lane), 32'(exp_l[i]));
    end
    check("t2_cnt", 32'(bus_a.drained_cnt), 4);
    tick();
    check("t2_idle", 32'(bus_a.out_valid), 0);

    // Stall threshold on lane 2 with draining disabled
    do_reset("t3");
    in_valid_2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_2 = 32'h20 + 32'(i);
      tick();
      check("t3_stall_fill", 32'(bus_a.global_stall), (i >= 1) ? 1 : 0);
    end
    idle();
    check("t3_ovf", 32'(bus_a.overflow_2), 0);
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_odata", bus_a.out_data, 32'h20 + 32'(i));
      check("t3_olane", 32'(bus_a.out_lane), 1);
      check("t3_stall_drain", 32'(bus_a.global_stall), (i < 2) ? 1 : 0);
    end
    tick();
    check("t3_idle", 32'(bus_a.out_valid), 0);

    // Overflow on lane 1
    do_reset("t4");
    in_valid_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_1 = 32'h40 + 32'(i);
      tick();
      check("t4_ovf_fill", 32'(bus_a.overflow_1), (i == 4) ? 1 : 0);
    end
    idle();
    tick();
    check("t4_ovf_sticky", 32'(bus_a.overflow_1), 1);
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_odata", bus_a.out_data, 32'h40 + 32'(i));
    end
    tick();
    check("t4_idle", 32'(bus_a.out_valid), 0);
    check("t4_ovf_end", 32'(bus_a.overflow_1), 1);

    // Push and pop together on a full lane
    do_reset("t5");
    in_valid_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_1 = 32'h50 + 32'(i);
      tick();
    end
    in_data_1 = 32'h54;
    drain_en  = 1'b1;
    tick();
    in_valid_1 = 1'b0;
    check("t5_odata0", bus_a.out_data, 32'h50);
    check("t5_ovf", 32'(bus_a.overflow_1), 0);
    check("t5_stall", 32'(bus_a.global_stall), 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("t5_odata", bus_a.out_data, 32'h50 + 32'(i));
    end
    tick();
    check("t5_idle", 32'(bus_a.out_valid), 0);
    check("t5_ovf_end", 32'(bus_a.overflow_1), 0);

    // Streaming with random drain; producer honours the stall three samples late
    do_reset("t6");
    sent1 = 0; sent2 = 0; cyc = 0; got = 0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    while ((sent1 < 20 || sent2 < 20 || q1.size() != 0 || q2.size() != 0) && cyc < 2000) begin
      in_valid_1 = (sent1 < 20) && !h3;
      in_data_1  = 32'h1000 + 32'(sent1);
      if (in_valid_1) begin q1.push_back(in_data_1); sent1++; end
      in_valid_2 = (sent2 < 20) && !h3;
      in_data_2  = 32'h2000 + 32'(sent2);
      if (in_valid_2) begin q2.push_back(in_data_2); sent2++; end
      drain_en = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (bus_a.out_valid) begin
        got++;
        if (bus_a.out_lane == 1'b0) begin
          if (q1.size() == 0) check("t6_spurious_l1", 1, 0);
          else check("t6_l1_data", bus_a.out_data, q1.pop_front());
        end else begin
          if (q2.size() == 0) check("t6_spurious_l2", 1, 0);
          else check("t6_l2_data", bus_a.out_data, q2.pop_front());
        end
      end
      h3 = h2; h2 = h1; h1 = bus_a.global_stall;
    end
    idle();
    check("t6_timeout", 32'(cyc < 2000), 1);
    check("t6_got", 32'(got), 40);
    check("t6_cnt", 32'(bus_a.drained_cnt), 40);
    check("t6_ovf", 32'({bus_a.overflow_1, bus_a.overflow_2}), 0);

    // Drain period 2: opportunities on every second edge after reset release
    do_reset("t7");
    in_valid_1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data_1 = 32'h70 + 32'(i);
      tick();
    end
    idle();
    drain_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t7_ovalid", 32'(bus_b.out_valid), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) check("t7_odata", bus_b.out_data, 32'h70 + 32'(i / 2));
    end
    check("t7_cnt", 32'(bus_b.drained_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
